// File: rtl/five_sentence_pkg.sv
// Shared constants and types for the five-input majority voter.
`timescale 1ns/100ps
package five_sentence_pkg;

  localparam int NUM_VOTERS        = 5;
  localparam int COUNT_W           = 3;
  localparam int DEFAULT_THRESHOLD = 3;

  typedef logic [NUM_VOTERS-1:0] votes_t;
  typedef logic [COUNT_W-1:0]    count_t;

  typedef struct packed {
    logic   y;
    count_t count;
    logic   all_yes;
    logic   all_no;
  } status_t;

endpackage

// File: rtl/popcount5.sv
// Combinational population count of the five vote bits.
`timescale 1ns/100ps
module popcount5
  import five_sentence_pkg::*;
(
  input  votes_t votes,
  output count_t count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_VOTERS; i++) begin
      count = count + count_t'(votes[i]);
    end
  end

endmodule

// File: rtl/five_sentence_1.sv
// Registered five-input majority voter with vote count and unanimity flags.
`timescale 1ns/100ps
module five_sentence_1
  import five_sentence_pkg::*;
#(
  parameter int THRESHOLD = DEFAULT_THRESHOLD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         A,
  input  logic         B,
  input  logic         C,
  input  logic         D,
  input  logic         E,
  output logic         Y,
  output logic [2:0]   count,
  output logic         all_yes,
  output logic         all_no
);

  if (THRESHOLD < 1 || THRESHOLD > NUM_VOTERS) begin : g_bad_threshold
    $error("five_sentence_1: THRESHOLD must be in 1..5");
  end

  votes_t  votes;
  count_t  cnt_next;
  status_t status_next;
  status_t status_p0;

  assign votes = {A, B, C, D, E};

  popcount5 u_popcount5 (
    .votes (votes),
    .count (cnt_next)
  );

  always_comb begin
    status_next         = '0;
    status_next.count   = cnt_next;
    status_next.y       = (cnt_next >= count_t'(THRESHOLD));
    status_next.all_yes = (cnt_next == count_t'(NUM_VOTERS));
    status_next.all_no  = (cnt_next == '0);
  end

  // Stage p0: output register bank, all four outputs load on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_p0 <= '0;
    end else begin
      status_p0 <= status_next;
    end
  end

  assign Y       = status_p0.y;
  assign count   = status_p0.count;
  assign all_yes = status_p0.all_yes;
  assign all_no  = status_p0.all_no;

endmodule

// File: tb/tb_five_sentence_1.sv
// Directed bench for the five-input majority voter (THRESHOLD 3 and 5 instances).
`timescale 1ns/100ps
module tb_five_sentence_1;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0;
  logic       y3, all_yes3, all_no3;
  logic [2:0] count3;
  logic       y5, all_yes5, all_no5;
  logic [2:0] count5;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = clk_en ? ~clk : 1'b0;

  five_sentence_1 #(.THRESHOLD(3)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .C(c), .D(d), .E(e),
    .Y(y3), .count(count3), .all_yes(all_yes3), .all_no(all_no3)
  );

  five_sentence_1 #(.THRESHOLD(5)) dut5 (
    .clk(clk), .rst(rst), .A(a), .B(b), .C(c), .D(d), .E(e),
    .Y(y5), .count(count5), .all_yes(all_yes5), .all_no(all_no5)
  );

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, expv, $time);
  endtask

  task automatic set_votes(input logic [4:0] v);
    a = v[4]; b = v[3]; c = v[2]; d = v[1]; e = v[0];
  endtask

  function automatic int popc(input logic [4:0] v);
    int n = 0;
    for (int i = 0; i < 5; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic chk_all(input string tag, input int y, input int cnt,
                         input int ay, input int an);
    chk({tag, ".Y"}, int'(y3), y);
    chk({tag, ".count"}, int'(count3), cnt);
    chk({tag, ".all_yes"}, int'(all_yes3), ay);
    chk({tag, ".all_no"}, int'(all_no3), an);
  endtask

  task automatic apply(input logic [4:0] v);
    @(negedge clk);
    set_votes(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] v;
    logic [4:0] smp;
    int         pc;

    // Reset with no clock running: outputs clear immediately
    set_votes(5'b11111);
    #1 rst = 1'b1;
    #1 chk_all("rst_noclk", 0, 0, 0, 0);
    chk("rst_noclk.Y5", int'(y5), 0);
    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk_all("release", 1, 5, 1, 0);

    // Majority boundary
    apply(5'b11000); chk("bnd2.Y", int'(y3), 0); chk("bnd2.count", int'(count3), 2);
    apply(5'b11100); chk("bnd3.Y", int'(y3), 1); chk("bnd3.count", int'(count3), 3);
    apply(5'b00111); chk("bnd3b.Y", int'(y3), 1); chk("bnd3b.count", int'(count3), 3);

    // Unanimity
    apply(5'b00000); chk_all("none", 0, 0, 0, 1);
    apply(5'b11111); chk_all("all", 1, 5, 1, 0);
    apply(5'b01111); chk_all("four", 1, 4, 0, 0);

    // THRESHOLD=5 instance
    apply(5'b11110); chk("th5_4.Y", int'(y5), 0);
    apply(5'b11111); chk("th5_5.Y", int'(y5), 1);

    // Exhaustive sweep against the model
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      apply(v);
      pc = popc(v);
      chk_all($sformatf("sweep%0d", i), int'(pc >= 3), pc, int'(pc == 5), int'(pc == 0));
      chk($sformatf("sweep%0d.Y5", i), int'(y5), int'(pc == 5));
    end

    // Hold: static inputs keep outputs steady
    apply(5'b10101);
    @(posedge clk); #1;
    chk_all("hold", 1, 3, 0, 0);

    // Mid-run reset between edges while Y=1
    apply(5'b11111);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_all("midrst", 0, 0, 0, 0);
    set_votes(5'b01110);
    #1 rst = 1'b0;
    #1 chk_all("midrst_hold", 0, 0, 0, 0);
    @(posedge clk);
    #1 chk_all("midrst_rec", 1, 3, 0, 0);

    // Asynchronous staggered toggles; phase offset keeps them off the clock edges
    @(negedge clk);
    set_votes(5'b00000);
    @(posedge clk);
    #0.5;
    smp = 5'b00000;
    fork
      repeat (100) begin #2;  a = ~a; end
      repeat (66)  begin #3;  b = ~b; end
      repeat (40)  begin #5;  c = ~c; end
      repeat (28)  begin #7;  d = ~d; end
      repeat (18)  begin #11; e = ~e; end
      repeat (18) begin
        @(posedge clk);
        smp = {a, b, c, d, e};
        #1;
        pc = popc(smp);
        chk("tog.count", int'(count3), pc);
        chk("tog.Y", int'(y3), int'(pc >= 3));
        @(negedge clk);
        chk("tog.count_mid", int'(count3), pc);
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/five_sentence_1.md
Name: five_sentence_1

Overview:
Five-input majority voter: inputs A..E are individual yes(1)/no(0) votes; Y asserts when the number of yes votes reaches the threshold (default 3 of 5, i.e. strict majority). Inputs are sampled and results registered on the clock, giving glitch-free outputs for downstream LED/status logic. Auxiliary outputs report the yes-vote count and unanimous conditions.

Parameters:
THRESHOLD, 3, minimum yes-vote count for Y=1; legal range 1..5; values outside are a compile-time error.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous reset, active-high
A  input  1  vote 1 (1 = yes)
B  input  1  vote 2
C  input  1  vote 3
D  input  1  vote 4
E  input  1  vote 5
Y  output  1  registered result: 1 when yes-count >= THRESHOLD
count  output  3  registered yes-vote count, 0..5
all_yes  output  1  registered: all five votes are 1
all_no  output  1  registered: all five votes are 0

Interface:
- One clock (clk); reset rst is asynchronous and active-high.
- Inputs are synchronous to clk; no internal synchronizers.

Behaviour:
- Reset: on rst=1, immediately (no clock needed) Y=0, count=0, all_yes=0, all_no=0; held while rst=1.
- Release: first rising clk edge with rst=0 loads outputs from the current inputs.
- Each rising clk edge (rst=0):
  - count <= A+B+C+D+E, zero-extended to 3 bits; max 5, no overflow.
  - Y <= (A+B+C+D+E >= THRESHOLD).
  - all_yes <= (count_next == 5).
  - all_no <= (count_next == 0).
- Latency: exactly 1 cycle from input change (stable before the edge) to the output update; all four outputs update on the same edge and are mutually consistent.
- Y is a pure function of the vote count: order and identity of voters are irrelevant.
- With THRESHOLD=3, the boundary cases are:
  - count=2 -> Y=0.
  - count=3 -> Y=1.
- all_no=1 and Y=1 can never coexist for THRESHOLD>=1.
- all_yes implies Y for any legal THRESHOLD.
- Reset asserted mid-operation: outputs clear asynchronously; the inputs present at that moment are discarded.
- No combinational path from inputs to outputs.
- Outputs hold their values whenever inputs are static.

Decomposition:
- Shared package, five_sentence_pkg:
  - NUM_VOTERS=5.
  - COUNT_W=3.
  - Default threshold constant DEFAULT_THRESHOLD=3.
- Sub-module popcount5: purely combinational; 5-bit vector in, 3-bit count out.
- Top level contains:
  - Threshold compare.
  - Unanimity decode.
  - Output register bank with asynchronous reset.

Test Plan:
- Reset: assert rst with inputs 11111 and no clock -> Y=0, count=0, all_yes=0, all_no=0 immediately; release rst, one edge later -> Y=1, count=5, all_yes=1, all_no=0.
- Majority boundary: ABCDE=11000 -> after 1 edge Y=0, count=2; then 11100 -> Y=1, count=3; then 00111 -> Y=1, count=3.
- Exhaustive sweep: all 32 input combinations, one per cycle -> Y equals (popcount>=3) and count equals the popcount, each one cycle late, checked against a reference model.
- Unanimity: 00000 -> all_no=1, Y=0, count=0; 11111 -> all_yes=1, Y=1, count=5; 01111 -> both flags 0, Y=1, count=4.
- Asynchronous toggle stimulus: toggle A, B, C, D, E at staggered intervals of 2, 3, 5, 7 and 11 ns, each independently, with a 10 ns clock -> outputs change only on rising clk edges and always match the inputs sampled at that edge.
- Parameter and mid-run reset:
  - THRESHOLD=5 with inputs 11110 -> Y=0; with 11111 -> Y=1.
  - rst pulse between clock edges while Y=1 -> Y drops immediately; outputs recover on the first edge after release.
